// File: rtl/mult.sv
// -----------------------------------------------------------------------------
// mult : multicycle signed WIDTH x WIDTH multiplier (radix-2 Booth)
//
// Computes the full 2*WIDTH-bit two's-complement product of srcA and srcB,
// one Booth iteration per clock, WIDTH iterations per operation.
//
// Ports
//   clk       in   system clock, all state updates on the rising edge
//   reset     in   synchronous, active-high reset (highest priority)
//   srcA      in   multiplicand, two's complement (sampled on init only)
//   srcB      in   multiplier, two's complement (sampled on init only)
//   multCtrl  in   init strobe: load operands and (re)start
//   multRun   out  high while iterations are in progress
//   multDone  out  one-cycle pulse when hi/lo hold the new product
//   hi        out  product bits [2*WIDTH-1:WIDTH]
//   lo        out  product bits [WIDTH-1:0]
//
// Handshake: the control unit pulses multCtrl for one cycle (edge N), then
// waits while multRun is high. Iterations happen on edges N+1..N+WIDTH; in
// the cycle after edge N+WIDTH multRun is low, multDone is high for exactly
// one cycle and hi/lo carry the product, which they then hold until the next
// init or reset. A new multCtrl at any time aborts and restarts; reset aborts
// without a multDone pulse. hi/lo read zero from init until completion.
// -----------------------------------------------------------------------------
module mult #(
   parameter int WIDTH = 32
) (
   input  logic             clk,
   input  logic             reset,
   input  logic [WIDTH-1:0] srcA,
   input  logic [WIDTH-1:0] srcB,
   input  logic             multCtrl,
   output logic             multRun,
   output logic             multDone,
   output logic [WIDTH-1:0] hi,
   output logic [WIDTH-1:0] lo
);

   localparam int CNT_W = $clog2(WIDTH) + 1;
   localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(WIDTH - 1);

   typedef enum logic {
      IDLE = 1'b0,
      RUN  = 1'b1
   } state_e;

   state_e           state_q;
   // Multiplicand and accumulator carry one extra bit so that -M cannot
   // overflow when srcA is the most negative value.
   logic [WIDTH:0]   m_q;
   logic [WIDTH:0]   acc_q;
   logic [WIDTH-1:0] q_q;
   logic             qm1_q;
   logic [CNT_W-1:0] cnt_q;
   logic [WIDTH-1:0] hi_q;
   logic [WIDTH-1:0] lo_q;
   logic             run_q;
   logic             done_q;

   logic [WIDTH:0]   acc_sum;
   logic [WIDTH:0]   acc_d;
   logic [WIDTH-1:0] q_d;
   logic             qm1_d;
   logic [CNT_W-1:0] cnt_d;

   // One Booth step: add/subtract M according to {Q[0],Qm1}, then shift the
   // whole {Acc,Q,Qm1} chain right arithmetically by one.
   always_comb begin
      acc_sum = acc_q;
      unique case ({q_q[0], qm1_q})
         2'b01:   acc_sum = acc_q + m_q;
         2'b10:   acc_sum = acc_q - m_q;
         default: acc_sum = acc_q;
      endcase
      acc_d = {acc_sum[WIDTH], acc_sum[WIDTH:1]};
      q_d   = {acc_sum[0], q_q[WIDTH-1:1]};
      qm1_d = q_q[0];
      cnt_d = cnt_q + CNT_W'(1);
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q <= IDLE;
         m_q     <= '0;
         acc_q   <= '0;
         q_q     <= '0;
         qm1_q   <= 1'b0;
         cnt_q   <= '0;
         hi_q    <= '0;
         lo_q    <= '0;
         run_q   <= 1'b0;
         done_q  <= 1'b0;
      end else if (multCtrl) begin
         // Init wins over a run in progress: the old product is discarded.
         state_q <= RUN;
         m_q     <= {srcA[WIDTH-1], srcA};
         acc_q   <= '0;
         q_q     <= srcB;
         qm1_q   <= 1'b0;
         cnt_q   <= '0;
         hi_q    <= '0;
         lo_q    <= '0;
         run_q   <= 1'b1;
         done_q  <= 1'b0;
      end else begin
         done_q <= 1'b0;
         unique case (state_q)
            IDLE: begin
               // hold the last product
            end
            RUN: begin
               acc_q <= acc_d;
               q_q   <= q_d;
               qm1_q <= qm1_d;
               cnt_q <= cnt_d;
               if (cnt_q == LAST_CNT) begin
                  // hi/lo only ever take the finished product.
                  hi_q    <= acc_d[WIDTH-1:0];
                  lo_q    <= q_d;
                  run_q   <= 1'b0;
                  done_q  <= 1'b1;
                  state_q <= IDLE;
               end
            end
            default: state_q <= IDLE;
         endcase
      end
   end

   assign multRun  = run_q;
   assign multDone = done_q;
   assign hi       = hi_q;
   assign lo       = lo_q;

endmodule

// File: tb/tb_mult.sv
// -----------------------------------------------------------------------------
// tb_mult : self-checking bench for mult.
// Table of directed vectors, randomized vectors against a signed-arithmetic
// reference, and hand-written sequences for hold, abort and reset corners.
// -----------------------------------------------------------------------------
module tb_mult;

   localparam int W = 32;
   localparam int LAT = 32;

   logic         clk = 1'b0;
   logic         reset;
   logic [W-1:0] srcA, srcB;
   logic         multCtrl;
   logic         multRun, multDone;
   logic [W-1:0] hi, lo;

   int checks = 0;
   int errors = 0;

   typedef struct {
      logic [W-1:0] a;
      logic [W-1:0] b;
      logic [W-1:0] exp_hi;
      logic [W-1:0] exp_lo;
   } vec_t;

   vec_t vecs[6];

   mult #(.WIDTH(W)) dut (
      .clk(clk), .reset(reset), .srcA(srcA), .srcB(srcB), .multCtrl(multCtrl),
      .multRun(multRun), .multDone(multDone), .hi(hi), .lo(lo)
   );

   // clock / reset
   always #5 clk = ~clk;

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
      end
   endtask

   // Reference: full signed product computed with 64-bit arithmetic.
   function automatic logic [63:0] ref_prod(input logic [W-1:0] a, input logic [W-1:0] b);
      longint pa, pb;
      pa = longint'($signed(a));
      pb = longint'($signed(b));
      return 64'(pa * pb);
   endfunction

   // Driver: pulse multCtrl, wait for multDone, check handshake and product.
   // chg_at >= 0 scrambles srcA/srcB that many cycles into the run.
   task automatic do_mult(input logic [W-1:0] a, input logic [W-1:0] b,
                          input logic [63:0] exp_p, input int chg_at, input string name);
      int lat;
      bit run_ok, zero_ok;
      logic [W-1:0] h0, l0;
      srcA = a; srcB = b; multCtrl = 1'b1;
      @(negedge clk);
      multCtrl = 1'b0;
      lat = 0; run_ok = 1; zero_ok = 1;
      while (!multDone && lat < LAT + 8) begin
         if (!multRun) run_ok = 0;
         if (hi !== '0 || lo !== '0) zero_ok = 0;
         if (lat == chg_at) begin
            srcA = $urandom; srcB = $urandom;
         end
         @(negedge clk);
         lat++;
      end
      chk({name, " latency"}, 64'(lat), 64'(LAT));
      chk({name, " run_high"}, 64'(run_ok), 64'd1);
      chk({name, " hilo_zero_during_run"}, 64'(zero_ok), 64'd1);
      chk({name, " run_low_at_done"}, 64'(multRun), 64'd0);
      chk({name, " product"}, {hi, lo}, exp_p);
      h0 = hi; l0 = lo;
      @(negedge clk);
      chk({name, " done_one_cycle"}, 64'(multDone), 64'd0);
      chk({name, " hold"}, {hi, lo}, {h0, l0});
   endtask

   initial begin
      int waited;
      bit seen_done;
      logic [W-1:0] ra, rb;

      vecs[0] = '{32'd3,        32'd5,        32'h0000_0000, 32'h0000_000F};
      vecs[1] = '{32'hFFFF_FFFD, 32'd5,       32'hFFFF_FFFF, 32'hFFFF_FFF1};
      vecs[2] = '{32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h0000_0000, 32'h0000_0001};
      vecs[3] = '{32'h8000_0000, 32'h8000_0000, 32'h4000_0000, 32'h0000_0000};
      vecs[4] = '{32'h8000_0000, 32'hFFFF_FFFF, 32'h0000_0000, 32'h8000_0000};
      vecs[5] = '{32'h7FFF_FFFF, 32'h7FFF_FFFF, 32'h3FFF_FFFF, 32'h0000_0001};

      // reset
      reset = 1'b1; multCtrl = 1'b0; srcA = '0; srcB = '0;
      repeat (3) @(negedge clk);
      chk("reset hi", 64'(hi), 64'd0);
      chk("reset lo", 64'(lo), 64'd0);
      chk("reset run", 64'(multRun), 64'd0);
      chk("reset done", 64'(multDone), 64'd0);
      reset = 1'b0;
      @(negedge clk);

      // directed table (vector 5 also scrambles operands 2 cycles in)
      for (int i = 0; i < 6; i++) begin
         do_mult(vecs[i].a, vecs[i].b, {vecs[i].exp_hi, vecs[i].exp_lo},
                 (i == 5) ? 2 : -1, $sformatf("vec%0d", i));
      end

      // hi/lo stable through 10 idle cycles
      begin
         logic [63:0] last_p;
         bit stable;
         last_p = {hi, lo}; stable = 1;
         repeat (10) begin
            @(negedge clk);
            if ({hi, lo} !== last_p || multDone !== 1'b0 || multRun !== 1'b0) stable = 0;
         end
         chk("idle stable", 64'(stable), 64'd1);
         chk("idle value", last_p, {32'h3FFF_FFFF, 32'h0000_0001});
      end

      // randomized against the reference
      for (int i = 0; i < 20; i++) begin
         ra = $urandom; rb = $urandom;
         if (i == 0) ra = '0;
         if (i == 1) rb = 32'h8000_0000;
         do_mult(ra, rb, ref_prod(ra, rb), -1, $sformatf("rand%0d", i));
      end

      // multCtrl held high: reloads each cycle, last operands win
      srcA = 32'd5; srcB = 32'd5; multCtrl = 1'b1;
      @(negedge clk);
      chk("hold run", 64'(multRun), 64'd1);
      srcA = 32'd4; srcB = 32'hFFFF_FFF0;
      @(negedge clk);
      chk("hold hilo zero", {hi, lo}, 64'd0);
      do_mult(32'd11, 32'hFFFF_FFF3, ref_prod(32'd11, 32'hFFFF_FFF3), -1, "held");

      // abort by re-init at iteration 10
      srcA = 32'd7; srcB = 32'd9; multCtrl = 1'b1;
      @(negedge clk);
      multCtrl = 1'b0;
      seen_done = 0;
      repeat (10) begin
         if (multDone) seen_done = 1;
         @(negedge clk);
      end
      chk("abort no done", 64'(seen_done), 64'd0);
      do_mult(32'd6, 32'd7, 64'd42, -1, "restart");

      // reset at iteration 20
      srcA = 32'd100; srcB = 32'd100; multCtrl = 1'b1;
      @(negedge clk);
      multCtrl = 1'b0;
      repeat (20) @(negedge clk);
      reset = 1'b1;
      @(negedge clk);
      reset = 1'b0;
      chk("rst_run hilo", {hi, lo}, 64'd0);
      chk("rst_run run", 64'(multRun), 64'd0);
      seen_done = 0;
      waited = 0;
      while (waited < LAT + 5) begin
         if (multDone || multRun) seen_done = 1;
         @(negedge clk);
         waited++;
      end
      chk("rst_run quiet", 64'(seen_done), 64'd0);
      do_mult(32'd2, 32'd3, 64'd6, -1, "after_reset");

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

   // Global time limit so the bench always ends.
   initial begin
      #200000;
      $display("FAIL timeout: simulation did not complete");
      $fatal(1, "timeout");
   end

endmodule

// File: doc/mult.md
Name: mult

Overview:
- Multicycle signed 32x32 multiplier for the CPU datapath; the counterpart of the multicycle divider.
- Takes the two register-file operands and produces the 64-bit signed product on the HI/LO registers (hi = upper word, lo = lower word) for MULT.
- Radix-2 Booth, one iteration per clock, 32 iterations.
- Started by a one-cycle init strobe from the control unit, which waits on multRun/multDone.

Parameters:
- WIDTH, 32, operand width; product is 2*WIDTH; iteration count = WIDTH.

Ports:
- clk  input  1  system clock, all state updates on rising edge
- reset  input  1  synchronous, active-high reset
- srcA  input  WIDTH  multiplicand, two's complement
- srcB  input  WIDTH  multiplier, two's complement
- multCtrl  input  1  MultInit strobe: load operands and start
- multRun  output  1  high while iterations are in progress
- multDone  output  1  one-cycle pulse when hi/lo hold the new product
- hi  output  WIDTH  product bits [2*WIDTH-1:WIDTH]
- lo  output  WIDTH  product bits [WIDTH-1:0]

Behaviour:
- Reset (sync, active-high, highest priority):
  - hi=0, lo=0, multRun=0, multDone=0.
  - Internal accumulator, multiplier register, Q-1 bit and counter cleared; state IDLE.
- States: IDLE, RUN.
- Internal registers:
  - M: WIDTH+1-bit multiplicand, sign-extended srcA.
  - Acc: WIDTH+1 bits, so that -M never overflows when srcA = 0x80000000.
  - Q: WIDTH bits.
  - Qm1: 1 bit.
  - cnt: 6 bits.
- multCtrl=1 (any state, reset low), on that edge:
  - M = sext(srcA), Acc=0, Q=srcB, Qm1=0, cnt=0.
  - hi=0, lo=0, multRun=1, multDone=0; state RUN.
  - srcA/srcB are sampled only on this edge; later changes are ignored.
- RUN with multCtrl=0, one iteration per edge:
  - {Q[0],Qm1} = 01 -> Acc = Acc + M.
  - {Q[0],Qm1} = 10 -> Acc = Acc - M.
  - {Q[0],Qm1} = 00 or 11 -> Acc unchanged.
  - Then arithmetic right shift of {Acc,Q,Qm1} by 1; Acc MSB replicates its sign.
  - cnt = cnt + 1.
- Completion, on the edge performing iteration cnt==WIDTH-1:
  - hi = Acc[WIDTH-1:0] after the final shift; lo = Q after the final shift.
  - multRun=0, multDone=1, state IDLE.
- Latency:
  - multCtrl sampled high at edge N; iterations on edges N+1..N+32.
  - hi/lo valid and multDone=1 in the cycle after edge N+32.
  - multRun is high from after edge N through edge N+32.
- multDone:
  - Exactly one cycle, cleared on the next edge.
  - Never asserted by reset or by an aborted run.
- hi/lo:
  - Hold the last product indefinitely in IDLE.
  - Read 0 from init until completion.
  - Never show partial products.
- multCtrl held high for several cycles: re-loads every cycle; iterations begin on the first edge after it drops.
- multCtrl during RUN: aborts the current operation, loads the new operands and restarts from cnt=0; the old product is lost and hi/lo are cleared.
- Reset during RUN: aborts; all outputs return to reset values; no multDone.
- Arithmetic:
  - Full signed product, no overflow flag; all 2^64 results are representable.
  - Unsigned multiply (MULTU) is out of scope.

Test Plan:
- srcA=3, srcB=5, pulse multCtrl -> multRun high for 32 cycles, then multDone one cycle; hi=0x00000000, lo=0x0000000F; hi/lo stable for 10 idle cycles.
- srcA=-3 (0xFFFFFFFD), srcB=5 -> hi=0xFFFFFFFF, lo=0xFFFFFFF1; then srcA=-1, srcB=-1 -> hi=0, lo=1.
- srcA=0x80000000, srcB=0x80000000 -> hi=0x40000000, lo=0; srcA=0x80000000, srcB=0xFFFFFFFF -> hi=0, lo=0x80000000.
- srcA=0x7FFFFFFF, srcB=0x7FFFFFFF -> hi=0x3FFFFFFF, lo=0x00000001; operands changed on cycle 2 after init have no effect.
- Start 7*9, re-pulse multCtrl at iteration 10 with 6*7 -> no multDone for the first run; multDone 32 cycles after the second strobe; lo=42, hi=0.
- Start 100*100, assert reset at iteration 20 -> hi=lo=0, multRun=0, multDone stays 0; a following 2*3 gives lo=6 after 32 cycles.
